// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch front end.
//   fetch_entry_t    : one {pc, instr} pair as held in the fetch queue
//   XLEN             : architectural address/instruction width
//   INSTR_BYTES      : fetch stride in bytes
//   DEFAULT_RESET_PC : default PC loaded on reset
//   align_pc()       : clears the byte-offset bits of a PC
package fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Instructions are word aligned, so the low offset bits carry no meaning.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & ~(XLEN'(INSTR_BYTES - 1));
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of fetch_entry_t.
//   clk, rst      : clock, asynchronous active-low reset
//   push/push_entry : enqueue request (ignored when full or flushing)
//   pop           : dequeue request (ignored when empty or flushing)
//   flush         : discard all entries; takes priority over push and pop
//   full, empty   : occupancy flags from registered state
//   head          : entry at the read pointer (registered storage only)
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t   mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   // A full queue refuses a push even if a pop happens the same cycle.
   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end.
//   clk, rst         : clock, asynchronous active-low reset
//   imem_pc          : fetch PC presented to instruction memory
//   imem_instr/valid : memory response for the current imem_pc
//   redirect_valid/pc: restart fetch at a new (word-aligned) PC, flushing the queue
//   out_valid/ready  : handshake toward decode
//   out_pc/out_instr : head of the fetch queue
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        imem_valid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   logic [31:0]  pc_q, pc_d;
   logic         q_full;
   logic         q_empty;
   logic         capture;
   logic         dequeue;
   fetch_entry_t push_entry;
   fetch_entry_t head;

   // Redirect wins over both capture and dequeue. While full, pc holds so
   // memory keeps presenting the same word until there is room for it.
   assign capture = imem_valid & ~q_full & ~redirect_valid;
   assign dequeue = out_valid & out_ready & ~redirect_valid;

   assign push_entry.pc    = pc_q;
   assign push_entry.instr = imem_instr;

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = align_pc(redirect_pc);
      end else if (capture) begin
         pc_d = pc_q + 32'(INSTR_BYTES);   // wraps modulo 2^32
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (capture),
      .push_entry(push_entry),
      .pop       (dequeue),
      .flush     (redirect_valid),
      .full      (q_full),
      .empty     (q_empty),
      .head      (head)
   );

   assign imem_pc   = pc_q;
   assign out_valid = ~q_empty;
   assign out_pc    = head.pc;
   assign out_instr = head.instr;

endmodule
